morse_assembler: RTL

MORSE_ASSEMBLER -- requirements
Module: morse_assembler

---
 rtl/morse_pkg.sv | 61 ++++++
 rtl/morse_lut.sv | 35 +++
 rtl/morse_assembler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse character assembler: FSM states,
// default character length, the unknown-character code and the
// International Morse decode function used by the lookup block.
package morse_pkg;

  localparam int MAX_LEN_DEF = 5;
  localparam logic [7:0] ASCII_UNK = 8'h3F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ERR     = 2'd2
  } state_e;

  // Decode {len, pattern}; pattern is right-aligned, first element at bit len-1,
  // 1 = dash, 0 = dot. Returns {found, ascii}.
  function automatic logic [8:0] morse_lookup(input logic [2:0] len, input logic [4:0] pat5);
    logic [8:0] res;
    case ({len, pat5})
      {3'd2, 5'b00001}: res = {1'b1, 8'h41}; // A .-
      {3'd4, 5'b01000}: res = {1'b1, 8'h42}; // B -...
      {3'd4, 5'b01010}: res = {1'b1, 8'h43}; // C -.-.
      {3'd3, 5'b00100}: res = {1'b1, 8'h44}; // D -..
      {3'd1, 5'b00000}: res = {1'b1, 8'h45}; // E .
      {3'd4, 5'b00010}: res = {1'b1, 8'h46}; // F ..-.
      {3'd3, 5'b00110}: res = {1'b1, 8'h47}; // G --.
      {3'd4, 5'b00000}: res = {1'b1, 8'h48}; // H ....
      {3'd2, 5'b00000}: res = {1'b1, 8'h49}; // I ..
      {3'd4, 5'b00111}: res = {1'b1, 8'h4A}; // J .---
      {3'd3, 5'b00101}: res = {1'b1, 8'h4B}; // K -.-
      {3'd4, 5'b00100}: res = {1'b1, 8'h4C}; // L .-..
      {3'd2, 5'b00011}: res = {1'b1, 8'h4D}; // M --
      {3'd2, 5'b00010}: res = {1'b1, 8'h4E}; // N -.
      {3'd3, 5'b00111}: res = {1'b1, 8'h4F}; // O ---
      {3'd4, 5'b00110}: res = {1'b1, 8'h50}; // P .--.
      {3'd4, 5'b01101}: res = {1'b1, 8'h51}; // Q --.-
      {3'd3, 5'b00010}: res = {1'b1, 8'h52}; // R .-.
      {3'd3, 5'b00000}: res = {1'b1, 8'h53}; // S ...
      {3'd1, 5'b00001}: res = {1'b1, 8'h54}; // T -
      {3'd3, 5'b00001}: res = {1'b1, 8'h55}; // U ..-
      {3'd4, 5'b00001}: res = {1'b1, 8'h56}; // V ...-
      {3'd3, 5'b00011}: res = {1'b1, 8'h57}; // W .--
      {3'd4, 5'b01001}: res = {1'b1, 8'h58}; // X -..-
      {3'd4, 5'b01011}: res = {1'b1, 8'h59}; // Y -.--
      {3'd4, 5'b01100}: res = {1'b1, 8'h5A}; // Z --..
      {3'd5, 5'b11111}: res = {1'b1, 8'h30}; // 0 -----
      {3'd5, 5'b01111}: res = {1'b1, 8'h31}; // 1 .----
      {3'd5, 5'b00111}: res = {1'b1, 8'h32}; // 2 ..---
      {3'd5, 5'b00011}: res = {1'b1, 8'h33}; // 3 ...--
      {3'd5, 5'b00001}: res = {1'b1, 8'h34}; // 4 ....-
      {3'd5, 5'b00000}: res = {1'b1, 8'h35}; // 5 .....
      {3'd5, 5'b10000}: res = {1'b1, 8'h36}; // 6 -....
      {3'd5, 5'b11000}: res = {1'b1, 8'h37}; // 7 --...
      {3'd5, 5'b11100}: res = {1'b1, 8'h38}; // 8 ---..
      {3'd5, 5'b11110}: res = {1'b1, 8'h39}; // 9 ----.
      default:          res = {1'b0, ASCII_UNK};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse decode: (element count, pattern) -> ASCII code.
// Patterns with any element beyond the fifth position are never valid.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic [2:0]         len,
  input  logic [MAX_LEN-1:0] pat,
  output logic [7:0]         ch,
  output logic               found
);

  localparam int W = MAX_LEN + 5;

  logic [W-1:0] ext_s;
  logic [8:0]   res_s;
  logic         hi_s;

  assign ext_s = W'(pat);
  assign hi_s  = |ext_s[W-1:5];

  // Table lookup, forced to "unknown" when bits above the table width are set.
  always_comb begin
    res_s = morse_lookup(len, ext_s[4:0]);
    if (hi_s) begin
      found = 1'b0;
      ch    = ASCII_UNK;
    end else begin
      found = res_s[8];
      ch    = res_s[7:0];
    end
  end

endmodule

// File: rtl/morse_assembler.sv
// Assembles dot/dash/gap strobes from a pulse classifier into characters.
// Elements shift into sreg (dash = 1); a long space emits the decoded
// character, or an error strobe if the character overflowed MAX_LEN.
module morse_assembler
  import morse_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sp,
  input  logic               lp,
  input  logic               ss,
  input  logic               ls,
  output logic               valid,
  output logic [7:0]         ch,
  output logic [2:0]         len,
  output logic [MAX_LEN-1:0] pat,
  output logic               unk,
  output logic               err
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               unk_q, unk_d;
  logic [7:0]         ch_q, ch_d;
  logic [2:0]         len_q, len_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;

  logic [7:0]         lut_ch_s;
  logic               lut_found_s;
  logic               elem_s;
  logic               ss_unused_s;

  // Inter-element gaps carry no information for assembly.
  assign ss_unused_s = ss;
  // An element is recorded only when no long space competes in the same cycle.
  assign elem_s = (sp | lp) & ~ls;

  morse_lut #(.MAX_LEN(MAX_LEN)) u_lut (
    .len   (3'(cnt_q)),
    .pat   (sreg_q),
    .ch    (lut_ch_s),
    .found (lut_found_s)
  );

  // Next-state and output logic; ls beats lp beats sp.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unk_d   = unk_q;
    ch_d    = ch_q;
    len_d   = len_q;
    pat_d   = pat_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (ls) begin
          if (state_q == COLLECT) begin
            valid_d = 1'b1;
            len_d   = 3'(cnt_q);
            pat_d   = sreg_q;
            ch_d    = lut_ch_s;
            unk_d   = ~lut_found_s;
            sreg_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            state_d = IDLE;
          end
        end else if (elem_s) begin
          if (cnt_q < CNT_W'(MAX_LEN)) begin
            sreg_d  = {sreg_q[MAX_LEN-2:0], lp};
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = COLLECT;
          end else begin
            state_d = ERR;
          end
        end else begin
          state_d = state_q;
        end
      end
      ERR: begin
        if (ls) begin
          err_d   = 1'b1;
          sreg_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = ERR;
        end
      end
      default: begin
        sreg_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unk_q   <= 1'b0;
      ch_q    <= 8'h00;
      len_q   <= 3'd0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      unk_q   <= unk_d;
      ch_q    <= ch_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
    end
  end

  assign valid = valid_q;
  assign err   = err_q;
  assign unk   = unk_q;
  assign ch    = ch_q;
  assign len   = len_q;
  assign pat   = pat_q;

endmodule
